signal_history_tracker: RTL and testbench
=========================================

# signal_history_tracker

Records the cycle timestamps (external `counter` values) at which a single 1-bit control signal was high, and answers two retrospective queries over that history. Pipeline-stage trackers use it to recover when a handshake or memory signal started or ended after they have already moved past that cycle. Each instance watches one signal. Queries return results one cycle after the request.

## Interface
- `DATA_WIDTH`, 1: width of `tracked_signal`; only 1 is supported, and only bit 0 is used.
- `BUFFER_SIZE`, 128: number of timestamp entries held in the circular history; power of two.
- `clk` in 1: clock; all logic on rising edge.
- `rst` in 1: reset; synchronous and active-high.
- `counter` in 32 signed: global cycle count; increments by 1 every clock.
- `tracked_signal` in DATA_WIDTH: signal being recorded.
- `value_in` in 32 signed: look-back distance for the time query.
- `recalculate_time` in 1: time-query request strobe.
- `time_out[1:0]` out 2×32 signed: [0] = interval start, [1] = interval end; -1 means not found.
- `range_in[0:1]` in 2×32 signed: inclusive [low, high] window for the single-cycle query.
- `recalculate_single_cycle` in 1: single-cycle query request strobe.
- `single_cycle_out` out 32 signed: matching timestamp, or -1.
- `previous_end_i` in 32 signed: end time of the last consumed interval.
- `update_end` in 1: load `previous_end_i` into the floor register.
- `previous_end_memory` in 1: the last consumed interval was a memory access.
- `ready_flag` in 1: time query tracks contiguous runs (handshake mode).
- `ex_ready_flag` in 1: time query ignores the floor.
- `data_mem_req_flag` in 1: single-cycle query returns the latest match instead of the earliest.

## Operation
- **Recording:** every clock with `tracked_signal`=1, write `counter` at the write pointer and advance the pointer modulo BUFFER_SIZE. Count saturates at BUFFER_SIZE. When full, the oldest entry is overwritten.
- **Floor:** on `update_end`=1, set `floor <= previous_end_i` and `floor_incl <= previous_end_memory`.
  - `floor_incl`=1: entries ≤ floor are consumed.
  - `floor_incl`=0: only entries < floor are consumed, so a shared boundary cycle stays visible.
- **Eligibility:** an entry is eligible if it is not consumed by the floor (skipped when `ex_ready_flag`=1), and it is < C, where C is `counter` at the request edge. The current cycle's level is the caller's responsibility.
- **Time query** (`recalculate_time`):
  - Lower bound L = C − `value_in`.
  - S = earliest eligible entry ≥ L. If none, `time_out` = {-1,-1}.
  - `ready_flag`=1: E = last entry of the consecutive-value run starting at S. If E = C−1, the signal may still be high and `time_out[1]` = -1; otherwise `time_out` = {S, E}.
  - `ready_flag`=0: `time_out` = {S, S}.
- **Single-cycle query** (`recalculate_single_cycle`):
  - Eligible entries with `range_in[0]` ≤ ts ≤ `range_in[1]`.
  - Returns the earliest match, or the latest if `data_mem_req_flag`=1; -1 if none.
  - If `range_in[0]` > `range_in[1]`, returns -1.
- Both queries may fire in the same cycle and are served independently.
- Outputs hold their value until the next request of the same kind.

## Timing
- **Reset:** clears the history, count, pointer, floor (0) and `floor_incl` (0); `time_out` = {-1,-1}; `single_cycle_out` = -1.
- **Latency:** a request sampled at edge N yields its output registered at edge N, visible during cycle N+1. Strobes are single-cycle pulses; holding a strobe re-evaluates every cycle.
- **Request order per edge:**
  - Queries use the history as it stood before this edge's write, and the floor before this edge's `update_end`.
  - The write and floor update then take effect.
- **Reset priority:** `rst` overrides record, query and floor update in the same cycle; any in-flight result is discarded.
- **Arithmetic:** 32-bit signed, no saturation; wrap of `counter` is out of scope.
- **Search:** combinational over all BUFFER_SIZE entries, masked by valid count. Age order is derived from the write pointer, not from timestamp magnitude.

## Configuration
- `SIGNAL_HISTORY_OVERFLOW_EN` defined: adds output `overflow` (1 bit, reset 0). It is set sticky when a write overwrites an entry that has not been consumed by the floor, and cleared only by `rst`.
- Undefined: no port; overwrites are silent.

## Test plan
- **Handshake run:** signal high at counter 10–12, `ready_flag`=1, query at C=20 with `value_in`=15 → `time_out`={10,12}.
- **Ongoing run:** signal high 18–19, query at C=20 with `value_in`=5 → `time_out`={18,-1}. Empty history → {-1,-1}.
- **Floor boundary:** entries 5 and 9, `update_end` with `previous_end_i`=5. `previous_end_memory`=1 → query starts at 9; `previous_end_memory`=0 → starts at 5. `ex_ready_flag`=1 → 5 in both cases.
- **Single-cycle query:** entries 30, 33, 36, `range_in`={31,40} → 33; with `data_mem_req_flag`=1 → 36; `range_in`={40,31} → -1.
- **Wrap-around:** BUFFER_SIZE=4, six high cycles at 1–6 → earliest visible entry is 3; overflow flag (if enabled) = 1.
- **Reset mid-query:** `rst` asserted with `recalculate_time` in the same cycle → outputs -1, history empty.

Source files
------------

// File: rtl/signal_history_tracker_if.sv
// Request/response bundle between a pipeline tracker and one signal_history_tracker.
// The overflow flag exists only when SIGNAL_HISTORY_OVERFLOW_EN is defined.
interface signal_history_tracker_if #(
    parameter int DATA_WIDTH = 1
);
    logic signed [31:0]    counter;
    logic [DATA_WIDTH-1:0] tracked_signal;
    logic signed [31:0]    value_in;
    logic                  recalculate_time;
    logic signed [31:0]    time_out [1:0];
    logic signed [31:0]    range_in [0:1];
    logic                  recalculate_single_cycle;
    logic signed [31:0]    single_cycle_out;
    logic signed [31:0]    previous_end_i;
    logic                  update_end;
    logic                  previous_end_memory;
    logic                  ready_flag;
    logic                  ex_ready_flag;
    logic                  data_mem_req_flag;
`ifdef SIGNAL_HISTORY_OVERFLOW_EN
    logic                  overflow;

    modport master (
        output counter, tracked_signal, value_in, recalculate_time, range_in,
               recalculate_single_cycle, previous_end_i, update_end, previous_end_memory,
               ready_flag, ex_ready_flag, data_mem_req_flag,
        input  time_out, single_cycle_out, overflow
    );

    modport slave (
        input  counter, tracked_signal, value_in, recalculate_time, range_in,
               recalculate_single_cycle, previous_end_i, update_end, previous_end_memory,
               ready_flag, ex_ready_flag, data_mem_req_flag,
        output time_out, single_cycle_out, overflow
    );
`else
    modport master (
        output counter, tracked_signal, value_in, recalculate_time, range_in,
               recalculate_single_cycle, previous_end_i, update_end, previous_end_memory,
               ready_flag, ex_ready_flag, data_mem_req_flag,
        input  time_out, single_cycle_out
    );

    modport slave (
        input  counter, tracked_signal, value_in, recalculate_time, range_in,
               recalculate_single_cycle, previous_end_i, update_end, previous_end_memory,
               ready_flag, ex_ready_flag, data_mem_req_flag,
        output time_out, single_cycle_out
    );
`endif
endinterface

// File: rtl/signal_history_tracker.sv
// Circular history of the counter values at which one control signal was high, with time and
// single-cycle retrospective queries. Define SIGNAL_HISTORY_OVERFLOW_EN for the sticky overflow flag.
module signal_history_tracker #(
    parameter int DATA_WIDTH  = 1,
    parameter int BUFFER_SIZE = 128
) (
    input  logic                           clk,
    input  logic                           rst,
    signal_history_tracker_if.slave        bus
);
    localparam int PTR_W = (BUFFER_SIZE > 1) ? $clog2(BUFFER_SIZE) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic signed [31:0]    r_mem [BUFFER_SIZE];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [CNT_W-1:0]      r_count;
    logic signed [31:0]    r_floor;
    logic                  r_floor_incl;
    logic signed [31:0]    r_time_out [1:0];
    logic signed [31:0]    r_single;

    logic [DATA_WIDTH-1:0] w_sig;
    logic                  w_full;
    logic [PTR_W-1:0]      w_oldest;
    logic signed [31:0]    w_lower;
    logic                  w_t_found;
    logic                  w_t_in_run;
    logic signed [31:0]    w_t_start;
    logic signed [31:0]    w_t_end;
    logic signed [31:0]    w_t_end_out;
    logic                  w_s_found;
    logic signed [31:0]    w_s_ts;

    assign w_sig    = bus.tracked_signal;
    assign w_full   = (r_count == CNT_W'(BUFFER_SIZE));
    assign w_oldest = w_full ? r_wr_ptr : '0;
    assign w_lower  = bus.counter - bus.value_in;

    // Walk entries oldest-first; the write pointer, not timestamp magnitude, defines age.
    always_comb begin
        logic [PTR_W-1:0]   idx;
        logic signed [31:0] ts;
        logic               valid;
        logic               elig;
        idx        = '0;
        ts         = '0;
        valid      = 1'b0;
        elig       = 1'b0;
        w_t_found  = 1'b0;
        w_t_in_run = 1'b0;
        w_t_start  = -32'sd1;
        w_t_end    = -32'sd1;
        w_s_found  = 1'b0;
        w_s_ts     = -32'sd1;
        for (int k = 0; k < BUFFER_SIZE; k++) begin
            idx   = w_oldest + PTR_W'(k);
            ts    = r_mem[idx];
            valid = (k < int'(r_count));
            elig  = valid && (ts < bus.counter) &&
                    (bus.ex_ready_flag || (r_floor_incl ? (ts > r_floor) : (ts >= r_floor)));
            if (w_t_in_run) begin
                if (valid && (ts == w_t_end + 32'sd1)) begin
                    w_t_end = ts;
                end else begin
                    w_t_in_run = 1'b0;
                end
            end else if (!w_t_found && elig && (ts >= w_lower)) begin
                w_t_found  = 1'b1;
                w_t_in_run = 1'b1;
                w_t_start  = ts;
                w_t_end    = ts;
            end
            if (elig && (ts >= bus.range_in[0]) && (ts <= bus.range_in[1])) begin
                if (!w_s_found || bus.data_mem_req_flag) begin
                    w_s_ts = ts;
                end
                w_s_found = 1'b1;
            end
        end
    end

    // A run reaching the previous cycle may still be in progress, so its end is unknown.
    always_comb begin
        w_t_end_out = -32'sd1;
        if (w_t_found) begin
            if (!bus.ready_flag) begin
                w_t_end_out = w_t_start;
            end else if (w_t_end != bus.counter - 32'sd1) begin
                w_t_end_out = w_t_end;
            end
        end
    end

`ifdef SIGNAL_HISTORY_OVERFLOW_EN
    logic               r_overflow;
    logic signed [31:0] w_victim;
    logic               w_victim_consumed;

    assign w_victim          = r_mem[r_wr_ptr];
    assign w_victim_consumed = r_floor_incl ? (w_victim <= r_floor) : (w_victim < r_floor);
    assign bus.overflow      = r_overflow;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr      <= '0;
            r_count       <= '0;
            r_floor       <= '0;
            r_floor_incl  <= 1'b0;
            r_time_out[0] <= -32'sd1;
            r_time_out[1] <= -32'sd1;
            r_single      <= -32'sd1;
`ifdef SIGNAL_HISTORY_OVERFLOW_EN
            r_overflow    <= 1'b0;
`endif
        end else begin
            if (bus.recalculate_time) begin
                r_time_out[0] <= w_t_start;
                r_time_out[1] <= w_t_end_out;
            end
            if (bus.recalculate_single_cycle) begin
                r_single <= w_s_ts;
            end
            if (w_sig[0]) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                if (!w_full) begin
                    r_count <= r_count + CNT_W'(1);
                end
`ifdef SIGNAL_HISTORY_OVERFLOW_EN
                if (w_full && !w_victim_consumed) begin
                    r_overflow <= 1'b1;
                end
`endif
            end
            if (bus.update_end) begin
                r_floor      <= bus.previous_end_i;
                r_floor_incl <= bus.previous_end_memory;
            end
        end
    end

    // Storage needs no reset; the valid count masks stale entries.
    always_ff @(posedge clk) begin
        if (!rst && w_sig[0]) begin
            r_mem[r_wr_ptr] <= bus.counter;
        end
    end

    assign bus.time_out[0]     = r_time_out[0];
    assign bus.time_out[1]     = r_time_out[1];
    assign bus.single_cycle_out = r_single;
endmodule

// File: tb/tb_signal_history_tracker.sv
// Directed and randomized bench for signal_history_tracker against a queue-based history model.
module tb_signal_history_tracker;
    localparam int N = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    signal_history_tracker_if #(.DATA_WIDTH(1)) bus ();

    signal_history_tracker #(.DATA_WIDTH(1), .BUFFER_SIZE(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int hist[$];
    int mFloor = 0;
    bit mIncl = 1'b0;
    int expT0 = -1;
    int expT1 = -1;
    int expS = -1;
    bit expOvf = 1'b0;
    int checks = 0;
    int failures = 0;

    function automatic bit eligible(int ts, int c, bit ex, int fl, bit incl);
        return (ts < c) && (ex || (incl ? (ts > fl) : (ts >= fl)));
    endfunction

    // One clock edge: update the model from the inputs sampled at the edge, then advance time.
    task automatic applyStimulus();
        int c;
        int lo;
        int hi;
        int j;
        bit found;
        @(posedge clk);
        c = bus.counter;
        if (rst) begin
            hist.delete();
            mFloor = 0;
            mIncl  = 1'b0;
            expT0  = -1;
            expT1  = -1;
            expS   = -1;
            expOvf = 1'b0;
        end else begin
            if (bus.recalculate_time) begin
                expT0 = -1;
                expT1 = -1;
                for (int i = 0; i < hist.size(); i++) begin
                    if (eligible(hist[i], c, bus.ex_ready_flag, mFloor, mIncl) &&
                        hist[i] >= c - bus.value_in) begin
                        j = i;
                        while (j + 1 < hist.size() && hist[j+1] == hist[j] + 1) j++;
                        expT0 = hist[i];
                        if (!bus.ready_flag) expT1 = hist[i];
                        else expT1 = (hist[j] == c - 1) ? -1 : hist[j];
                        break;
                    end
                end
            end
            if (bus.recalculate_single_cycle) begin
                lo = bus.range_in[0];
                hi = bus.range_in[1];
                found = 1'b0;
                expS = -1;
                for (int i = 0; i < hist.size(); i++) begin
                    if (eligible(hist[i], c, bus.ex_ready_flag, mFloor, mIncl) &&
                        hist[i] >= lo && hist[i] <= hi) begin
                        if (!found || bus.data_mem_req_flag) expS = hist[i];
                        found = 1'b1;
                    end
                end
            end
            if (bus.tracked_signal[0]) begin
                if (hist.size() == N) begin
                    if (!(mIncl ? (hist[0] <= mFloor) : (hist[0] < mFloor))) expOvf = 1'b1;
                    void'(hist.pop_front());
                end
                hist.push_back(c);
            end
            if (bus.update_end) begin
                mFloor = bus.previous_end_i;
                mIncl  = bus.previous_end_memory;
            end
        end
        #1;
        bus.counter = bus.counter + 1;
        bus.tracked_signal = 1'b0;
        bus.recalculate_time = 1'b0;
        bus.recalculate_single_cycle = 1'b0;
        bus.update_end = 1'b0;
        rst = 1'b0;
    endtask

    task automatic checkValue(string tag, logic signed [31:0] obs, logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(string tag);
        checkValue({tag, ".time0"}, bus.time_out[0], expT0);
        checkValue({tag, ".time1"}, bus.time_out[1], expT1);
        checkValue({tag, ".single"}, bus.single_cycle_out, expS);
`ifdef SIGNAL_HISTORY_OVERFLOW_EN
        checkValue({tag, ".overflow"}, {31'b0, bus.overflow}, {31'b0, expOvf});
`endif
    endtask

    task automatic resetDut();
        rst = 1'b1;
        applyStimulus();
        rst = 1'b1;
        applyStimulus();
        bus.counter = 0;
        checkOutput("reset");
        checkValue("reset.time0c", bus.time_out[0], -1);
        checkValue("reset.singlec", bus.single_cycle_out, -1);
    endtask

    task automatic idleTo(int target);
        while (bus.counter < target) begin
            applyStimulus();
            checkOutput("idle");
        end
    endtask

    task automatic highAt(int first, int last);
        idleTo(first);
        while (bus.counter <= last) begin
            bus.tracked_signal = 1'b1;
            applyStimulus();
            checkOutput("record");
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.counter = 0;
        bus.tracked_signal = 1'b0;
        bus.value_in = 0;
        bus.recalculate_time = 1'b0;
        bus.range_in[0] = 0;
        bus.range_in[1] = 0;
        bus.recalculate_single_cycle = 1'b0;
        bus.previous_end_i = 0;
        bus.update_end = 1'b0;
        bus.previous_end_memory = 1'b0;
        bus.ready_flag = 1'b0;
        bus.ex_ready_flag = 1'b0;
        bus.data_mem_req_flag = 1'b0;

        // Handshake run 10..12 queried at 20
        resetDut();
        highAt(10, 12);
        idleTo(20);
        bus.ready_flag = 1'b1;
        bus.value_in = 15;
        bus.recalculate_time = 1'b1;
        applyStimulus();
        checkOutput("handshake");
        checkValue("handshake.start", bus.time_out[0], 10);
        checkValue("handshake.end", bus.time_out[1], 12);

        // Empty history, then an ongoing run
        resetDut();
        idleTo(2);
        bus.value_in = 5;
        bus.recalculate_time = 1'b1;
        applyStimulus();
        checkOutput("empty");
        checkValue("empty.start", bus.time_out[0], -1);
        checkValue("empty.end", bus.time_out[1], -1);
        highAt(18, 19);
        idleTo(20);
        bus.value_in = 5;
        bus.recalculate_time = 1'b1;
        applyStimulus();
        checkOutput("ongoing");
        checkValue("ongoing.start", bus.time_out[0], 18);
        checkValue("ongoing.end", bus.time_out[1], -1);
        bus.ready_flag = 1'b0;
        bus.recalculate_time = 1'b1;
        applyStimulus();
        checkOutput("noready");
        checkValue("noready.end", bus.time_out[1], 18);

        // Floor boundary handling and ordering against the query
        resetDut();
        highAt(5, 5);
        highAt(9, 9);
        idleTo(10);
        bus.update_end = 1'b1;
        bus.previous_end_i = 5;
        bus.previous_end_memory = 1'b1;
        applyStimulus();
        checkOutput("floorload");
        bus.value_in = 11;
        bus.recalculate_time = 1'b1;
        applyStimulus();
        checkOutput("floorincl");
        checkValue("floorincl.start", bus.time_out[0], 9);
        bus.update_end = 1'b1;
        bus.previous_end_memory = 1'b0;
        applyStimulus();
        bus.recalculate_time = 1'b1;
        applyStimulus();
        checkOutput("floorexcl");
        checkValue("floorexcl.start", bus.time_out[0], 5);
        bus.ex_ready_flag = 1'b1;
        bus.update_end = 1'b1;
        bus.previous_end_memory = 1'b1;
        bus.recalculate_time = 1'b1;
        applyStimulus();
        checkOutput("floorsame");
        bus.recalculate_time = 1'b1;
        applyStimulus();
        checkOutput("exready");
        checkValue("exready.start", bus.time_out[0], 5);
        bus.ex_ready_flag = 1'b0;
        bus.recalculate_time = 1'b1;
        applyStimulus();
        checkOutput("floorafter");
        checkValue("floorafter.start", bus.time_out[0], 9);

        // Single-cycle window query
        resetDut();
        highAt(30, 30);
        highAt(33, 33);
        highAt(36, 36);
        idleTo(40);
        bus.range_in[0] = 31;
        bus.range_in[1] = 40;
        bus.recalculate_single_cycle = 1'b1;
        applyStimulus();
        checkOutput("single");
        checkValue("single.earliest", bus.single_cycle_out, 33);
        bus.data_mem_req_flag = 1'b1;
        bus.recalculate_single_cycle = 1'b1;
        applyStimulus();
        checkOutput("singlelate");
        checkValue("single.latest", bus.single_cycle_out, 36);
        bus.range_in[0] = 40;
        bus.range_in[1] = 31;
        bus.recalculate_single_cycle = 1'b1;
        applyStimulus();
        checkOutput("singleinv");
        checkValue("single.inverted", bus.single_cycle_out, -1);
        bus.data_mem_req_flag = 1'b0;

        // Wrap-around: N+2 writes leave entry 3 as the oldest
        resetDut();
        highAt(1, N + 2);
        idleTo(N + 4);
        bus.value_in = 100;
        bus.recalculate_time = 1'b1;
        bus.range_in[0] = 0;
        bus.range_in[1] = 1000;
        bus.recalculate_single_cycle = 1'b1;
        applyStimulus();
        checkOutput("wrap");
        checkValue("wrap.start", bus.time_out[0], 3);
        checkValue("wrap.single", bus.single_cycle_out, 3);
`ifdef SIGNAL_HISTORY_OVERFLOW_EN
        checkValue("wrap.overflow", {31'b0, bus.overflow}, 1);
`endif

        // Reset collides with queries; the history must come back empty
        rst = 1'b1;
        bus.recalculate_time = 1'b1;
        bus.recalculate_single_cycle = 1'b1;
        applyStimulus();
        checkOutput("rstquery");
        checkValue("rstquery.time0", bus.time_out[0], -1);
        checkValue("rstquery.single", bus.single_cycle_out, -1);
        bus.recalculate_time = 1'b1;
        bus.recalculate_single_cycle = 1'b1;
        applyStimulus();
        checkOutput("postrst");
        checkValue("postrst.time0", bus.time_out[0], -1);

        // Randomized traffic against the model
        resetDut();
        for (int n = 0; n < 1500; n++) begin
            rst = ($urandom_range(199, 0) == 0);
            bus.tracked_signal = ($urandom_range(9, 0) < 6);
            bus.value_in = int'($urandom_range(40, 0));
            bus.recalculate_time = $urandom_range(1, 0) == 1;
            bus.range_in[0] = bus.counter - int'($urandom_range(40, 0));
            bus.range_in[1] = bus.range_in[0] + int'($urandom_range(30, 0)) - 5;
            bus.recalculate_single_cycle = $urandom_range(1, 0) == 1;
            bus.previous_end_i = bus.counter - int'($urandom_range(30, 0));
            bus.update_end = ($urandom_range(9, 0) == 0);
            bus.previous_end_memory = $urandom_range(1, 0) == 1;
            bus.ready_flag = $urandom_range(1, 0) == 1;
            bus.ex_ready_flag = ($urandom_range(3, 0) == 0);
            bus.data_mem_req_flag = $urandom_range(1, 0) == 1;
            applyStimulus();
            checkOutput("random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
